// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - binary32 field widths, bias constants and field struct shared by FPU units
package fpu_pkg;

  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS = 127;
  // exponent of a value whose leading one sits at bit 31 of a 32-bit integer
  localparam int INT_TO_F32_EXP_BASE = F32_BIAS + 31;

  typedef struct packed {
    logic sign;
    logic [F32_EXP_W-1:0] exp;
    logic [F32_MAN_W-1:0] man;
  } f32_t;

  function automatic f32_t f32_pack(input logic sign, input logic [F32_EXP_W+F32_MAN_W-1:0] mag);
    f32_t f;
    f.sign = sign;
    f.exp = mag[F32_EXP_W+F32_MAN_W-1:F32_MAN_W];
    f.man = mag[F32_MAN_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter (returns 32 for zero input)
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  cnt
);

  // each tree node: v = any one below it, c = zeros above its first one
  logic        v1 [16];
  logic [0:0]  c1 [16];
  logic        v2 [8];
  logic [1:0]  c2 [8];
  logic        v3 [4];
  logic [2:0]  c3 [4];
  logic        v4 [2];
  logic [3:0]  c4 [2];
  logic        v5;
  logic [4:0]  c5;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      v1[i] = a[2*i+1] | a[2*i];
      c1[i] = ~a[2*i+1];
    end
    for (int i = 0; i < 8; i++) begin
      v2[i] = v1[2*i+1] | v1[2*i];
      c2[i] = v1[2*i+1] ? {1'b0, c1[2*i+1]} : {1'b1, c1[2*i]};
    end
    for (int i = 0; i < 4; i++) begin
      v3[i] = v2[2*i+1] | v2[2*i];
      c3[i] = v2[2*i+1] ? {1'b0, c2[2*i+1]} : {1'b1, c2[2*i]};
    end
    for (int i = 0; i < 2; i++) begin
      v4[i] = v3[2*i+1] | v3[2*i];
      c4[i] = v3[2*i+1] ? {1'b0, c3[2*i+1]} : {1'b1, c3[2*i]};
    end
    v5 = v4[1] | v4[0];
    c5 = v4[1] ? {1'b0, c4[1]} : {1'b1, c4[0]};
    cnt = v5 ? {1'b0, c5} : 6'd32;
  end

endmodule

// File: rtl/itof.sv
// rtl/itof.sv - 3-stage signed int32 to binary32 converter, round-to-nearest-even
module itof
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        ready,
  output logic [31:0] y,
  output logic        valid
);

  // stage 1: sign and magnitude
  logic        s1_sign;
  logic [31:0] s1_mag;
  logic        v1;

  // stage 2: normalized magnitude and exponent
  logic [5:0]           lz;
  logic [31:0]          n_c;
  logic [F32_EXP_W-1:0] e_c;
  logic                 s2_sign;
  logic [31:0]          s2_n;
  logic [F32_EXP_W-1:0] s2_exp;
  logic                 s2_zero;
  logic                 v2;

  // stage 3: rounding
  logic [F32_MAN_W-1:0]           m_c;
  logic                           g_c;
  logic                           st_c;
  logic                           r_c;
  logic [F32_EXP_W+F32_MAN_W-1:0] p_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1 <= 1'b0;
    end else begin
      v1 <= ready;
    end
    s1_sign <= x[31];
    s1_mag  <= x[31] ? (~x + 32'd1) : x;
  end

  lzc32 u_lzc (
    .a   (s1_mag),
    .cnt (lz)
  );

  always_comb begin
    n_c = s1_mag << lz;
    // only meaningful for nonzero magnitude; the zero flag masks it later
    e_c = 8'(INT_TO_F32_EXP_BASE) - {2'b00, lz};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
    end
    s2_sign <= s1_sign;
    s2_n    <= n_c;
    s2_exp  <= e_c;
    s2_zero <= (s1_mag == 32'd0);
  end

  always_comb begin
    m_c  = s2_n[30:8];
    g_c  = s2_n[7];
    st_c = |s2_n[6:0];
    r_c  = g_c & (st_c | s2_n[8]);
    // a mantissa overflow carries straight into the exponent field
    p_c  = {s2_exp, m_c} + {30'd0, r_c};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y     <= 32'h0;
      valid <= 1'b0;
    end else begin
      valid <= v2;
      if (v2) begin
        y <= s2_zero ? 32'h0 : f32_pack(s2_sign, p_c);
      end
    end
  end

endmodule

// File: tb/tb_itof.sv
// tb/tb_itof.sv - randomized self-checking bench for itof against an arithmetic reference
module tb_itof;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic        ready;
  logic [31:0] y;
  logic        valid;

  itof dut (
    .clk   (clk),
    .rstn  (rstn),
    .x     (x),
    .ready (ready),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] y;
    string       tag;
  } exp_t;

  exp_t        expq[$];
  int          cyc = 0;
  logic [31:0] last_y = 32'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  // reference: exact magnitude, keep 24 significant bits, compare discarded remainder to half
  function automatic logic [31:0] ref_itof(input logic [31:0] xv);
    longint unsigned mag, q, rem, half;
    int msb, ex, sh;
    logic sgn;
    sgn = xv[31];
    mag = sgn ? (64'd4294967296 - {32'd0, xv}) : {32'd0, xv};
    if (mag == 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) msb = i;
    ex = 127 + msb;
    if (msb <= 23) begin
      q = mag << (23 - msb);
    end else begin
      sh = msb - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        ex = ex + 1;
      end
    end
    return {sgn, 8'(ex), q[22:0]};
  endfunction

  // model bookkeeping: a reset edge discards every in-flight operand
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      expq.delete();
      last_y = 32'h0;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (expq.size() != 0 && expq[0].due == cyc) begin
        check({expq[0].tag, "_valid"}, {31'd0, valid}, 32'd1);
        check(expq[0].tag, y, expq[0].y);
        last_y = expq[0].y;
        void'(expq.pop_front());
      end else begin
        check("idle_valid", {31'd0, valid}, 32'd0);
        check("hold_y", y, last_y);
      end
    end
  end

  task automatic launch(input logic [31:0] xv, input logic [31:0] want, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    ready = 1'b1;
    x = xv;
    e.due = cyc + 3;
    e.y = want;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ready = 1'b0;
      x = $urandom;
    end
  endtask

  initial begin
    logic [31:0] r;
    rstn = 1'b0;
    ready = 1'b0;
    x = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    launch(32'd1, 32'h3F800000, "one");
    launch(32'hFFFFFFFF, 32'hBF800000, "minus_one");
    bubble(4);

    launch(32'd0, 32'h00000000, "zero");
    launch(32'h80000000, 32'hCF000000, "int_min");
    launch(32'h7FFFFFFF, 32'h4F000000, "int_max");
    launch(32'd16777217, 32'h4B800000, "tie_down");
    launch(32'd16777219, 32'h4B800002, "tie_up");
    launch(32'd16777221, 32'h4B800002, "tie_221");
    launch(-32'sd16777219, 32'hCB800002, "tie_neg");
    bubble(4);

    launch(32'd2, 32'h40000000, "tp_2");
    launch(32'd3, 32'h40400000, "tp_3");
    bubble(1);
    launch(-32'sd8, 32'hC1000000, "tp_m8");
    bubble(5);

    launch(32'd5, 32'h40A00000, "flushed_5");
    launch(32'd6, 32'h40C00000, "flushed_6");
    @(posedge clk);
    #1;
    ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    launch(32'd7, 32'h40E00000, "after_rst_7");
    bubble(4);

    for (int k = 0; k < 32; k++) begin
      r = 32'd1 << k;
      launch(r, ref_itof(r), "pow2");
      r = -r;
      launch(r, ref_itof(r), "neg_pow2");
    end

    for (int i = 0; i < 30000; i++) begin
      case ($urandom_range(0, 3))
        0: r = $urandom & 32'h01FFFFFF;
        1: r = $urandom >> $urandom_range(0, 31);
        default: r = $urandom;
      endcase
      launch(r, ref_itof(r), "rand");
      if ($urandom_range(0, 9) == 0) bubble(1);
    end
    bubble(6);

    check("drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
